dac_output: RTL
===============

# dac_output

Drives the board's 10-bit SPI DAC (MCP4911-style 16-bit write frame) from the effects chain. Once per sample frame it captures the sign-magnitude `sendVoltage`, converts it to a midscale-offset unsigned code, and shifts the frame out MSB first. It then pulses LDAC so the analog output updates once per frame. It sits directly downstream of the effects stage and shares its free-running 10-bit frame `counter`.

## Interface
- `LATCH_SLOT`, 10'h5: `counter` value at which `sendVoltage` is captured. It must be later than the last effects accumulation slot.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles. Must be ≥1, and 34*CLK_DIV must be less than 1024.
- `CONFIG`, 4'b0011: frame bits [15:12], giving channel A, unbuffered, gain 1x, active.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `counter` in 10: sample-frame slot counter.
- `sendVoltage` in 11: sign-magnitude sample; bit 10 is the sign, bits [9:0] are the magnitude.
- `mute` in 1: when 1, the captured code is forced to midscale.
- `dacSclk` out 1: SPI clock, idles low.
- `dacSdi` out 1: SPI data.
- `dacCs` out 1: active-low chip select.
- `dacLdac` out 1: active-low latch strobe.
- `busy` out 1: high while a frame is in flight.
- `dacCode` out 10: last captured code (debug).
- `overruns` out 8: saturating count of dropped captures.

## Operation
- **Code conversion** at capture:
  - half = magnitude[9:1].
  - code = 512 + half when sign = 0, and 512 − half when sign = 1.
  - The range is 1..1023, so no clamp is needed. Negative zero maps to 512.
  - `mute` forces code = 512.
- **Frame format:** shift register loaded with {CONFIG, code, 2'b00}, 16 bits, shifted out MSB first.
- **FSM states:**
  - IDLE: capture when counter == LATCH_SLOT, then go to SHIFT.
  - SHIFT: 16 bits, 32 SCLK half-periods, then go to HOLD.
  - HOLD: `dacCs` high for CLK_DIV cycles, then go to LDAC.
  - LDAC: `dacLdac` low for CLK_DIV cycles, then go to IDLE.
- **SPI behaviour:**
  - A half-period counter counts 0..CLK_DIV−1 and toggles `dacSclk` at terminal count.
  - `dacSdi` changes only when `dacSclk` falls, or on SHIFT entry.
  - The DAC samples `dacSdi` on the SCLK rising edge.
- **Overrun:** if counter == LATCH_SLOT while not in IDLE, the sample is dropped, the frame in flight continues, and `overruns` increments, saturating at 8'hFF.
- **No recapture:** a capture happens at most once per LATCH_SLOT cycle. A `counter` that stalls at LATCH_SLOT for multiple cycles captures only on the first cycle, tracked by a one-cycle-delayed match flag.
- **Reset values:**
  - state IDLE, `dacSclk` 0, `dacSdi` 0, `dacCs` 1, `dacLdac` 1, `busy` 0.
  - `dacCode` 10'd512, `overruns` 0, shift register 0, delayed match flag 0.
- **Reset mid-frame:** asserting `reset` mid-frame aborts it immediately and asynchronously. `dacCs` goes high, and no LDAC pulse occurs.

## Timing
- Let T be the cycle in which the capture condition is sampled. `dacCode` is valid at T+1.
- From T+1:
  - `busy` goes high, `dacCs` goes low, and `dacSdi` carries frame bit 15 with `dacSclk` low.
  - Frame bit (15−i) has its SCLK rising edge at T+1+(2i+1)*CLK_DIV and its falling edge at T+1+(2i+2)*CLK_DIV, for i = 0..15.
- At T+1+32*CLK_DIV: the final SCLK falls, `dacCs` goes high, and `dacSdi` goes to 0.
- `dacLdac` is low from T+1+33*CLK_DIV through T+34*CLK_DIV inclusive.
- At T+1+34*CLK_DIV: `busy` goes low, and the block is idle and able to capture in that same cycle.
- Total busy time is 34*CLK_DIV cycles, which is 136 at the defaults. This is well under the 1024-cycle frame period.
- `dacCs` is never low while `dacLdac` is low.
- `dacSclk` is low whenever `dacCs` is high.

## Test plan
- **Positive sample:** sendVoltage = 11'h0C8 (+200) at counter 5, defaults → `dacCode` = 612, and SDI captured on the 16 SCLK rises = 16'h3990 (0011_1001100100_00). `dacLdac` is low for 4 cycles starting 133 cycles after capture.
- **Negative extreme / negative zero:** sendVoltage = 11'h7FF → code 1; sendVoltage = 11'h400 → code 512.
- **Mute:** mute = 1 with sendVoltage = 11'h3FF → code 512, frame 16'h3800.
- **Overrun:** hold `counter` at a value that re-hits 5 every 100 cycles (forced stimulus) → the second capture is dropped, `overruns` = 1, and the in-flight frame is bit-exact. Repeat 300 times → `overruns` saturates at 8'hFF.
- **Stall and reset:**
  - `counter` held at 5 for 10 cycles → exactly one frame.
  - `reset` low at cycle 40 of a frame → on that cycle `dacCs` = 1, `dacSclk` = 0, `busy` = 0, `dacCode` = 512, with no LDAC pulse. A normal frame follows after release.
- **CLK_DIV = 1:** busy spans exactly 34 cycles, SCLK toggles every cycle, and the SDI stream still matches the expected frame.

Source files
------------

// File: rtl/dac_output.sv
// dac_output: once per sample frame, converts the sign-magnitude effects sample to a
// midscale-offset 10-bit code and writes it to an MCP4911-style SPI DAC. The 16-bit
// frame goes out MSB first. LDAC is then pulsed so the analog output updates once per frame.
module dac_output #(
  parameter logic [9:0]  LATCH_SLOT = 10'h5,
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [3:0]  CONFIG     = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  counter,
  input  logic [10:0] sendVoltage,
  input  logic        mute,
  output logic        dacSclk,
  output logic        dacSdi,
  output logic        dacCs,
  output logic        dacLdac,
  output logic        busy,
  output logic [9:0]  dacCode,
  output logic [7:0]  overruns
);

  typedef enum logic [1:0] {StIdle, StShift, StHold, StLdac} state_e;

  // CLK_DIV is bounded by 34*CLK_DIV < 1024, so 5 bits always hold CLK_DIV-1
  localparam logic [4:0] HcLast = 5'(CLK_DIV - 1);

  state_e      r_state, w_state_nxt;
  logic [4:0]  r_hc, w_hc_nxt;        // half-period counter
  logic [4:0]  r_edge, w_edge_nxt;    // SCLK edges issued in this frame (0..31)
  logic [15:0] r_shift, w_shift_nxt;
  logic        r_sclk, w_sclk_nxt;
  logic        r_sdi, w_sdi_nxt;
  logic        r_cs, w_cs_nxt;
  logic        r_ldac, w_ldac_nxt;
  logic        r_busy, w_busy_nxt;
  logic [9:0]  r_code, w_code_nxt;
  logic [7:0]  r_ovr, w_ovr_nxt;
  logic        r_match;

  logic        w_match;
  logic        w_hit;
  logic        w_hc_tc;
  logic [9:0]  w_half;
  logic [9:0]  w_code_new;
  logic        w_unused_lsb;

  // the magnitude LSB is discarded by the halving
  assign w_unused_lsb = sendVoltage[0];

  // Capture only on the first cycle of a LATCH_SLOT match, so a stalled counter fires once
  assign w_match = (counter == LATCH_SLOT);
  assign w_hit   = w_match & ~r_match;
  assign w_hc_tc = (r_hc == HcLast);
  assign w_half  = {1'b0, sendVoltage[9:1]};

  // Sign-magnitude to offset code; range is 1..1023 so no clamp is required
  always_comb begin
    if (mute) begin
      w_code_new = 10'd512;
    end else if (sendVoltage[10]) begin
      w_code_new = 10'd512 - w_half;
    end else begin
      w_code_new = 10'd512 + w_half;
    end
  end

  // FSM next-state and SPI output logic
  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_edge_nxt  = r_edge;
    w_shift_nxt = r_shift;
    w_sclk_nxt  = r_sclk;
    w_sdi_nxt   = r_sdi;
    w_cs_nxt    = r_cs;
    w_ldac_nxt  = r_ldac;
    w_busy_nxt  = r_busy;
    w_code_nxt  = r_code;
    w_ovr_nxt   = r_ovr;

    // a capture request while a frame is in flight is dropped and counted
    if (w_hit && (r_state != StIdle) && (r_ovr != 8'hFF)) begin
      w_ovr_nxt = r_ovr + 8'd1;
    end

    case (r_state)
      StIdle: begin
        if (w_hit) begin
          w_state_nxt = StShift;
          w_code_nxt  = w_code_new;
          w_shift_nxt = {CONFIG, w_code_new, 2'b00};
          w_sdi_nxt   = CONFIG[3];
          w_cs_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_hc_nxt    = 5'd0;
          w_edge_nxt  = 5'd0;
          w_sclk_nxt  = 1'b0;
        end
      end
      StShift: begin
        if (w_hc_tc) begin
          w_hc_nxt   = 5'd0;
          w_sclk_nxt = ~r_sclk;
          w_edge_nxt = r_edge + 5'd1;
          // SDI only moves on a falling SCLK edge
          if (r_sclk) begin
            if (r_edge == 5'd31) begin
              w_state_nxt = StHold;
              w_cs_nxt    = 1'b1;
              w_sdi_nxt   = 1'b0;
            end else begin
              w_shift_nxt = r_shift << 1;
              w_sdi_nxt   = r_shift[14];
            end
          end
        end else begin
          w_hc_nxt = r_hc + 5'd1;
        end
      end
      StHold: begin
        if (w_hc_tc) begin
          w_hc_nxt    = 5'd0;
          w_state_nxt = StLdac;
          w_ldac_nxt  = 1'b0;
        end else begin
          w_hc_nxt = r_hc + 5'd1;
        end
      end
      StLdac: begin
        if (w_hc_tc) begin
          w_hc_nxt    = 5'd0;
          w_state_nxt = StIdle;
          w_ldac_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_hc_nxt = r_hc + 5'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers; reset aborts any frame with CS high and no LDAC pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_hc    <= 5'd0;
      r_edge  <= 5'd0;
      r_shift <= 16'd0;
      r_sclk  <= 1'b0;
      r_sdi   <= 1'b0;
      r_cs    <= 1'b1;
      r_ldac  <= 1'b1;
      r_busy  <= 1'b0;
      r_code  <= 10'd512;
      r_ovr   <= 8'd0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hc    <= w_hc_nxt;
      r_edge  <= w_edge_nxt;
      r_shift <= w_shift_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sdi   <= w_sdi_nxt;
      r_cs    <= w_cs_nxt;
      r_ldac  <= w_ldac_nxt;
      r_busy  <= w_busy_nxt;
      r_code  <= w_code_nxt;
      r_ovr   <= w_ovr_nxt;
      r_match <= w_match;
    end
  end

  assign dacSclk  = r_sclk;
  assign dacSdi   = r_sdi;
  assign dacCs    = r_cs;
  assign dacLdac  = r_ldac;
  assign busy     = r_busy;
  assign dacCode  = r_code;
  assign overruns = r_ovr;

endmodule
